// File: rtl/udp_tx.sv
// udp_tx: prepends an 8-byte UDP header beat to each payload packet and
// forwards it to the IPv4 transmit stage with the IP sideband user word.
// Packets whose length is zero or larger than one UDP datagram in a
// 1500-byte MTU (1472 bytes) are consumed, never forwarded, and counted.
module udp_tx #(
    parameter logic [15:0] P_SRC_PORT = 16'd8080,
    parameter logic [15:0] P_DST_PORT = 16'd8080
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_dynamic_src_port,
    input  logic        i_dynamic_src_valid,
    input  logic [15:0] i_dynamic_dst_port,
    input  logic        i_dynamic_dst_valid,
    input  logic [63:0] s_axis_user_data,
    input  logic [15:0] s_axis_user_user,
    input  logic [7:0]  s_axis_user_keep,
    input  logic        s_axis_user_last,
    input  logic        s_axis_user_valid,
    output logic        s_axis_user_ready,
    output logic [63:0] m_axis_ip_data,
    output logic [55:0] m_axis_ip_user,
    output logic [7:0]  m_axis_ip_keep,
    output logic        m_axis_ip_last,
    output logic        m_axis_ip_valid,
    input  logic        m_axis_ip_ready,
    output logic [15:0] o_drop_cnt
);

    localparam logic [15:0] MAX_PAYLOAD = 16'd1472;
    localparam logic [2:0]  IP_FLAGS_DF = 3'b010;
    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] pkt_id;
    logic [15:0] udp_len;
    logic        out_free;
    logic        len_bad;
    logic        load_hdr;
    logic        load_pay;
    logic        hdr_done;
    logic        drop_done;

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free = !m_axis_ip_valid || m_axis_ip_ready;
    assign len_bad  = (s_axis_user_user == 16'd0) || (s_axis_user_user > MAX_PAYLOAD);
    assign udp_len  = s_axis_user_user + 16'd8;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, input ready and the load/count strobes.
    always_comb begin
        state_nxt         = state;
        s_axis_user_ready = 1'b0;
        load_hdr          = 1'b0;
        load_pay          = 1'b0;
        hdr_done          = 1'b0;
        drop_done         = 1'b0;
        case (state)
            IDLE: begin
                // The first payload beat stays on the input until PAYLOAD.
                if (s_axis_user_valid && out_free) begin
                    if (len_bad) begin
                        state_nxt = DROP;
                    end else begin
                        load_hdr  = 1'b1;
                        state_nxt = HEADER;
                    end
                end
            end
            HEADER: begin
                if (m_axis_ip_ready) begin
                    hdr_done  = 1'b1;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                s_axis_user_ready = out_free;
                if (s_axis_user_valid && out_free) begin
                    load_pay = 1'b1;
                    if (s_axis_user_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                s_axis_user_ready = 1'b1;
                if (s_axis_user_valid && s_axis_user_last) begin
                    drop_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Port registers; sampled only when a header is built.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            src_port <= P_SRC_PORT;
            dst_port <= P_DST_PORT;
        end else begin
            if (i_dynamic_src_valid) begin
                src_port <= i_dynamic_src_port;
            end
            if (i_dynamic_dst_valid) begin
                dst_port <= i_dynamic_dst_port;
            end
        end
    end

    // IP identification advances once per forwarded header; drops are counted on their last beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_id     <= 16'd0;
            o_drop_cnt <= 16'd0;
        end else begin
            if (hdr_done) begin
                pkt_id <= pkt_id + 16'd1;
            end
            if (drop_done) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

    // Output register: header build, payload pass-through, or drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_axis_ip_data  <= 64'd0;
            m_axis_ip_user  <= 56'd0;
            m_axis_ip_keep  <= 8'hFF;
            m_axis_ip_last  <= 1'b0;
            m_axis_ip_valid <= 1'b0;
        end else if (load_hdr) begin
            // Checksum field left at zero: "not computed" is legal for UDP over IPv4.
            m_axis_ip_data  <= {src_port, dst_port, udp_len, 16'h0000};
            m_axis_ip_user  <= {udp_len, IP_FLAGS_DF, IP_PROTO_UDP, 13'd0, pkt_id};
            m_axis_ip_keep  <= 8'hFF;
            m_axis_ip_last  <= 1'b0;
            m_axis_ip_valid <= 1'b1;
        end else if (load_pay) begin
            m_axis_ip_data  <= s_axis_user_data;
            m_axis_ip_keep  <= s_axis_user_keep;
            m_axis_ip_last  <= s_axis_user_last;
            m_axis_ip_valid <= 1'b1;
        end else if (m_axis_ip_ready) begin
            m_axis_ip_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_udp_tx.sv
// Bench for udp_tx: table of packet lengths, hand-written corner sequences
// and randomized traffic, all scored against a packet-level reference model.
module tb_udp_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dyn_src_port;
    logic        dyn_src_valid;
    logic [15:0] dyn_dst_port;
    logic        dyn_dst_valid;
    logic [63:0] s_data;
    logic [15:0] s_user;
    logic [7:0]  s_keep;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] m_data;
    logic [55:0] m_user;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    udp_tx dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_dynamic_src_port  (dyn_src_port),
        .i_dynamic_src_valid (dyn_src_valid),
        .i_dynamic_dst_port  (dyn_dst_port),
        .i_dynamic_dst_valid (dyn_dst_valid),
        .s_axis_user_data    (s_data),
        .s_axis_user_user    (s_user),
        .s_axis_user_keep    (s_keep),
        .s_axis_user_last    (s_last),
        .s_axis_user_valid   (s_valid),
        .s_axis_user_ready   (s_ready),
        .m_axis_ip_data      (m_data),
        .m_axis_ip_user      (m_user),
        .m_axis_ip_keep      (m_keep),
        .m_axis_ip_last      (m_last),
        .m_axis_ip_valid     (m_valid),
        .m_axis_ip_ready     (m_ready),
        .o_drop_cnt          (drop_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [55:0] user;
    } beat_t;

    typedef struct {
        int unsigned len;
        bit          legal;
        logic [15:0] exp_len;
        logic [15:0] exp_drops;
    } vec_t;

    beat_t       exp_q[$];
    beat_t       prev_beat;
    bit          prev_stall;
    bit          mon_en;
    bit          s_acc;
    int          rdy_mode;
    int          checks = 0;
    int          errors = 0;

    // Reference model state: what the block should hold at packet level.
    logic [15:0] mdl_src;
    logic [15:0] mdl_dst;
    logic [15:0] mdl_id;
    logic [15:0] mdl_drops;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        beat_t cur;
        s_acc    = s_valid && s_ready;
        cur.data = m_data;
        cur.keep = m_keep;
        cur.last = m_last;
        cur.user = m_user;
        if (!mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data", m_data, prev_beat.data);
                check("hold_keep", 64'(m_keep), 64'(prev_beat.keep));
                check("hold_last", 64'(m_last), 64'(prev_beat.last));
                check("hold_user", 64'(m_user), 64'(prev_beat.user));
            end
            if (m_valid && !m_ready) begin
                check("s_ready_in_stall", 64'(s_ready), 64'd0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h user %h, expected no beat", m_data, m_user);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_data", m_data, e.data);
                    check("out_keep", 64'(m_keep), 64'(e.keep));
                    check("out_last", 64'(m_last), 64'(e.last));
                    check("out_user", 64'(m_user), 64'(e.user));
                end
            end
            prev_stall = m_valid && !m_ready;
        end
        prev_beat = cur;
    endtask

    // One clock: observe at the falling edge, then drive just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        dyn_src_valid = 1'b0;
        dyn_dst_valid = 1'b0;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Queue the expected output of one packet, then drive its beats.
    task automatic send_pkt(input int unsigned len, input bit legal, input logic [15:0] exp_len,
                            input int gap_pct, input int pulse_beat, input logic [15:0] pulse_src);
        int          nb;
        int          guard;
        int          rem;
        logic [63:0] d[$];
        logic [7:0]  k[$];
        logic [55:0] u;
        beat_t       b;
        nb = (len == 0) ? 1 : int'((len + 7) / 8);
        for (int i = 0; i < nb; i++) begin
            d.push_back({$urandom, $urandom});
            rem = int'(len) - 8 * i;
            if (i == nb - 1 && rem > 0 && rem < 8) begin
                k.push_back(8'hFF << (8 - rem));
            end else begin
                k.push_back(8'hFF);
            end
        end
        if (legal) begin
            u      = {exp_len, 3'b010, 8'd17, 13'd0, mdl_id};
            b.data = {mdl_src, mdl_dst, exp_len, 16'h0000};
            b.keep = 8'hFF;
            b.last = 1'b0;
            b.user = u;
            exp_q.push_back(b);
            mdl_id = mdl_id + 16'd1;
            for (int i = 0; i < nb; i++) begin
                b.data = d[i];
                b.keep = k[i];
                b.last = (i == nb - 1);
                b.user = u;
                exp_q.push_back(b);
            end
        end else begin
            mdl_drops = mdl_drops + 16'd1;
        end
        for (int i = 0; i < nb; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_valid = 1'b0;
                cycle();
            end
            s_valid = 1'b1;
            s_data  = d[i];
            s_keep  = k[i];
            s_last  = (i == nb - 1);
            s_user  = 16'(len);
            if (i == pulse_beat) begin
                dyn_src_port  = pulse_src;
                dyn_src_valid = 1'b1;
                mdl_src       = pulse_src;
            end
            guard = 0;
            do begin
                cycle();
                guard++;
            end while (!s_acc && guard < 500);
            if (!s_acc) begin
                checks++;
                errors++;
                $display("FAIL input_accept_timeout: beat %0d of len %0d not accepted in %0d cycles", i, len, guard);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || m_valid) && guard < 5000) begin
            cycle();
            guard++;
        end
        if (exp_q.size() != 0 || m_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats still expected, valid %0b", exp_q.size(), m_valid);
        end
    endtask

    task automatic port_pulse_idle(input bit is_src, input logic [15:0] val);
        if (is_src) begin
            dyn_src_port  = val;
            dyn_src_valid = 1'b1;
            mdl_src       = val;
        end else begin
            dyn_dst_port  = val;
            dyn_dst_valid = 1'b1;
            mdl_dst       = val;
        end
        cycle();
    endtask

    vec_t vecs[8];

    initial begin
        int unsigned len;
        int          r;

        vecs[0] = '{16,   1'b1, 16'd24,   16'd0};
        vecs[1] = '{13,   1'b1, 16'd21,   16'd0};
        vecs[2] = '{0,    1'b0, 16'd0,    16'd1};
        vecs[3] = '{1500, 1'b0, 16'd0,    16'd2};
        vecs[4] = '{8,    1'b1, 16'd16,   16'd2};
        vecs[5] = '{1472, 1'b1, 16'd1480, 16'd2};
        vecs[6] = '{1473, 1'b0, 16'd0,    16'd3};
        vecs[7] = '{1,    1'b1, 16'd9,    16'd3};

        rst_n         = 1'b0;
        dyn_src_port  = 16'd0;
        dyn_src_valid = 1'b0;
        dyn_dst_port  = 16'd0;
        dyn_dst_valid = 1'b0;
        s_data        = 64'd0;
        s_user        = 16'd0;
        s_keep        = 8'hFF;
        s_last        = 1'b0;
        s_valid       = 1'b0;
        m_ready       = 1'b1;
        rdy_mode      = 0;
        mon_en        = 1'b0;
        prev_stall    = 1'b0;
        mdl_src       = 16'd8080;
        mdl_dst       = 16'd8080;
        mdl_id        = 16'd0;
        mdl_drops     = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_keep", 64'(m_keep), 64'hFF);
        check("rst_m_data", m_data, 64'd0);
        check("rst_m_user", 64'(m_user), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Length table, full-rate downstream.
        for (int i = 0; i < 8; i++) begin
            send_pkt(vecs[i].len, vecs[i].legal, vecs[i].exp_len, 0, -1, 16'd0);
            drain();
            check("table_drop_cnt", 64'(drop_cnt), 64'(vecs[i].exp_drops));
        end

        // 64-byte packet with downstream ready toggling every cycle.
        rdy_mode = 1;
        send_pkt(64, 1'b1, 16'd72, 0, -1, 16'd0);
        drain();
        check("bp_drop_cnt", 64'(drop_cnt), 64'(mdl_drops));

        // Source port changed mid-payload: only the following header carries it.
        rdy_mode = 0;
        send_pkt(24, 1'b1, 16'd32, 0, 1, 16'h1234);
        send_pkt(8, 1'b1, 16'd16, 0, -1, 16'd0);
        drain();

        // Randomized traffic with random ready, gaps and port changes between packets.
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                len = $urandom_range(1473, 1600);
            end else if (r == 1) begin
                len = 0;
            end else if (r == 2) begin
                len = 1472;
            end else begin
                len = $urandom_range(1, 100);
            end
            if ($urandom_range(0, 3) == 0) begin
                port_pulse_idle(1'($urandom_range(0, 1)), 16'($urandom));
            end
            send_pkt(len, (len >= 1 && len <= 1472), 16'(len + 8), 20, -1, 16'd0);
        end
        drain();
        check("rand_drop_cnt", 64'(drop_cnt), 64'(mdl_drops));

        // Asynchronous reset in the middle of a payload.
        rdy_mode = 0;
        mon_en   = 1'b0;
        s_valid  = 1'b1;
        s_user   = 16'd32;
        s_data   = {$urandom, $urandom};
        s_keep   = 8'hFF;
        s_last   = 1'b0;
        repeat (4) cycle();
        check("pre_rst_valid", 64'(m_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(m_valid), 64'd0);
        check("midrst_s_ready", 64'(s_ready), 64'd0);
        check("midrst_m_data", m_data, 64'd0);
        check("midrst_m_user", 64'(m_user), 64'd0);
        check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        s_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        exp_q.delete();
        mdl_src   = 16'd8080;
        mdl_dst   = 16'd8080;
        mdl_id    = 16'd0;
        mdl_drops = 16'd0;
        mon_en    = 1'b1;
        send_pkt(16, 1'b1, 16'd24, 0, -1, 16'd0);
        send_pkt(0, 1'b0, 16'd0, 0, -1, 16'd0);
        drain();
        check("post_rst_drop_cnt", 64'(drop_cnt), 64'(mdl_drops));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
